// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipeline controller.
// master = stage/register side, slave = controller side.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    // Hazard information returned by the stages
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_Cnd;
    logic [3:0]       M_icode;
    logic [1:0]       m_stat;
    logic [1:0]       W_stat;

    // Pipeline register controls
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;

    // Status and performance counters
    logic             halted;
    logic [1:0]       exit_stat;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] ret_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  halted, exit_stat, stall_cnt, flush_cnt, ret_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode, m_stat, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output halted, exit_stat, stall_cnt, flush_cnt, ret_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline controller: stall/bubble generation for F/D/E/M/W, halt/exception
// drain state machine and saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);
    localparam logic [3:0] IcodeJxx    = 4'h7;
    localparam logic [3:0] IcodeRet    = 4'h9;
    localparam logic [3:0] IcodeMrmovq = 4'h5;
    localparam logic [3:0] IcodePopq   = 4'hB;
    localparam logic [3:0] RegNone     = 4'hF;
    localparam logic [1:0] StatAok     = 2'd0;

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StDrain  = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       exit_stat_q, exit_stat_d;
    // Set by reset, cleared at the first edge after release: forces the NOP-fill controls.
    logic             init_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, ret_cnt_q;

    logic lu, rt, mp, xm, xw;
    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall;
    logic count_en;

    // Hazard terms from the stage information
    always_comb begin
        lu = ((bus.E_icode == IcodeMrmovq) || (bus.E_icode == IcodePopq)) &&
             (bus.E_dstM != RegNone) &&
             ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        rt = (bus.D_icode == IcodeRet) || (bus.E_icode == IcodeRet) ||
             (bus.M_icode == IcodeRet);
        mp = (bus.E_icode == IcodeJxx) && !bus.e_Cnd;
        xm = (bus.m_stat != StatAok);
        xw = (bus.W_stat != StatAok);
    end

    // Stall/bubble controls from the current state and hazards
    always_comb begin
        f_stall  = lu | rt;
        d_stall  = lu;
        d_bubble = mp | (rt & ~lu);
        e_bubble = mp | lu;
        m_bubble = xm | xw;
        w_stall  = xw;
        if (init_q) begin
            f_stall  = 1'b0;
            d_stall  = 1'b0;
            w_stall  = 1'b0;
            d_bubble = 1'b1;
            e_bubble = 1'b1;
            m_bubble = 1'b1;
        end else begin
            case (state_q)
                StDrain: begin
                    f_stall  = 1'b1;
                    m_bubble = 1'b1;
                end
                StHalted: begin
                    f_stall  = 1'b1;
                    d_stall  = 1'b1;
                    w_stall  = 1'b1;
                    m_bubble = 1'b1;
                    d_bubble = 1'b0;
                    e_bubble = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Drain FSM next state; exit status captured on entry to HALTED
    always_comb begin
        state_d     = state_q;
        exit_stat_d = exit_stat_q;
        if ((state_q == StRun) || (state_q == StDrain)) begin
            if (xw) begin
                state_d     = StHalted;
                exit_stat_d = bus.W_stat;
            end else if ((state_q == StRun) && xm) begin
                state_d = StDrain;
            end
        end
    end

    // State, exit status and reset-fill flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            exit_stat_q <= StatAok;
            init_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            exit_stat_q <= exit_stat_d;
            init_q      <= 1'b0;
        end
    end

    assign count_en = (state_q == StRun) && !init_q;

    // Saturating event counters, live only while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            ret_cnt_q   <= '0;
        end else if (count_en) begin
            if (f_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (mp && (flush_cnt_q != '1))      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if ((bus.D_icode == IcodeRet) && !d_stall && (ret_cnt_q != '1)) begin
                ret_cnt_q <= ret_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.F_stall   = f_stall;
    assign bus.D_stall   = d_stall;
    assign bus.D_bubble  = d_bubble;
    assign bus.E_bubble  = e_bubble;
    assign bus.M_bubble  = m_bubble;
    assign bus.W_stall   = w_stall;
    assign bus.halted    = (state_q == StHalted);
    assign bus.exit_stat = exit_stat_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
    assign bus.ret_cnt   = ret_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized hazard traffic,
// compared every cycle against a behavioural model. A 4-bit-counter copy shares the stimulus.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(16)) bus ();
    pipe_ctrl_if #(.CNT_W(4))  bus4 ();

    assign bus4.D_icode = bus.D_icode;
    assign bus4.d_srcA  = bus.d_srcA;
    assign bus4.d_srcB  = bus.d_srcB;
    assign bus4.E_icode = bus.E_icode;
    assign bus4.E_dstM  = bus.E_dstM;
    assign bus4.e_Cnd   = bus.e_Cnd;
    assign bus4.M_icode = bus.M_icode;
    assign bus4.m_stat  = bus.m_stat;
    assign bus4.W_stat  = bus.W_stat;

    pipe_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipe_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          chk_en  = 1'b0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic f_stall;
        logic d_stall;
        logic d_bubble;
        logic e_bubble;
        logic m_bubble;
        logic w_stall;
    } ctl_t;

    // mode: 0 running, 1 draining, 2 halted
    int          m_mode;
    bit          m_init;
    logic [1:0]  m_exit;
    int unsigned m_stall, m_flush, m_ret;

    logic m_lu, m_rt, m_mp, m_xm, m_xw;
    assign m_lu = ((bus.E_icode == 4'h5) || (bus.E_icode == 4'hB)) && (bus.E_dstM != 4'hF) &&
                  ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    assign m_rt = (bus.D_icode == 4'h9) || (bus.E_icode == 4'h9) || (bus.M_icode == 4'h9);
    assign m_mp = (bus.E_icode == 4'h7) && !bus.e_Cnd;
    assign m_xm = (bus.m_stat != 2'd0);
    assign m_xw = (bus.W_stat != 2'd0);

    function automatic ctl_t model_ctl(input bit init, input int mode, input bit lu,
                                       input bit rt, input bit mp, input bit xm, input bit xw);
        ctl_t c;
        if (init) begin
            c.f_stall = 1'b0; c.d_stall = 1'b0; c.w_stall = 1'b0;
            c.d_bubble = 1'b1; c.e_bubble = 1'b1; c.m_bubble = 1'b1;
        end else if (mode == 2) begin
            c.f_stall = 1'b1; c.d_stall = 1'b1; c.w_stall = 1'b1;
            c.d_bubble = 1'b0; c.e_bubble = 1'b0; c.m_bubble = 1'b1;
        end else begin
            c.f_stall  = lu | rt | (mode == 1);
            c.d_stall  = lu;
            c.d_bubble = mp | (rt & !lu);
            c.e_bubble = mp | lu;
            c.m_bubble = xm | xw | (mode == 1);
            c.w_stall  = xw;
        end
        return c;
    endfunction

    ctl_t m_exp;
    assign m_exp = model_ctl(m_init, m_mode, m_lu, m_rt, m_mp, m_xm, m_xw);

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    // Model state: unbounded event counts, saturation applied when comparing
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_init  <= 1'b1;
            m_mode  <= 0;
            m_exit  <= 2'd0;
            m_stall <= 0;
            m_flush <= 0;
            m_ret   <= 0;
        end else begin
            m_init <= 1'b0;
            if (m_mode == 0 && !m_init) begin
                if (m_exp.f_stall) m_stall <= m_stall + 1;
                if (m_mp) m_flush <= m_flush + 1;
                if (bus.D_icode == 4'h9 && !m_exp.d_stall) m_ret <= m_ret + 1;
            end
            if (m_mode != 2 && m_xw) begin
                m_mode <= 2;
                m_exit <= bus.W_stat;
            end else if (m_mode == 0 && m_xm) begin
                m_mode <= 1;
            end
        end
    end

    // Per-cycle comparison on the falling edge, for both counter widths
    always @(negedge clk) begin
        if (chk_en) begin
            chk("F_stall",   bus.F_stall,  m_exp.f_stall);
            chk("D_stall",   bus.D_stall,  m_exp.d_stall);
            chk("D_bubble",  bus.D_bubble, m_exp.d_bubble);
            chk("E_bubble",  bus.E_bubble, m_exp.e_bubble);
            chk("M_bubble",  bus.M_bubble, m_exp.m_bubble);
            chk("W_stall",   bus.W_stall,  m_exp.w_stall);
            chk("D_excl",    bus.D_stall & bus.D_bubble, 0);
            chk("halted",    bus.halted,   m_mode == 2);
            chk("exit_stat", bus.exit_stat, m_exit);
            chk("stall_cnt", bus.stall_cnt, sat(m_stall, 65535));
            chk("flush_cnt", bus.flush_cnt, sat(m_flush, 65535));
            chk("ret_cnt",   bus.ret_cnt,   sat(m_ret, 65535));
            chk("w4.F_stall",   bus4.F_stall,  m_exp.f_stall);
            chk("w4.D_bubble",  bus4.D_bubble, m_exp.d_bubble);
            chk("w4.halted",    bus4.halted,   m_mode == 2);
            chk("w4.stall_cnt", bus4.stall_cnt, sat(m_stall, 15));
            chk("w4.flush_cnt", bus4.flush_cnt, sat(m_flush, 15));
            chk("w4.ret_cnt",   bus4.ret_cnt,   sat(m_ret, 15));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_clean();
        bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
        bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_Cnd = 1'b1;
        bus.M_icode = 4'h1; bus.m_stat = 2'd0; bus.W_stat = 2'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] pick_icode();
        case ($urandom_range(0, 7))
            0: return 4'h0;
            1: return 4'h1;
            2: return 4'h7;
            3: return 4'h9;
            4: return 4'h5;
            5: return 4'hB;
            6: return 4'h2;
            default: return 4'h6;
        endcase
    endfunction

    function automatic logic [3:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 4'h3;
            1: return 4'h4;
            2: return 4'hF;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic rand_inputs();
        bus.D_icode = pick_icode();
        bus.d_srcA  = pick_reg();
        bus.d_srcB  = pick_reg();
        bus.E_icode = pick_icode();
        bus.E_dstM  = pick_reg();
        bus.e_Cnd   = 1'($urandom_range(0, 1));
        bus.M_icode = pick_icode();
        bus.m_stat  = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        bus.W_stat  = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    endtask

    // Called just after a rising edge: reset low for half a cycle, then one clean fill cycle
    task automatic pulse_reset();
        rst_n = 1'b0;
        set_clean();
        #5;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        set_clean();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst.F_stall", bus.F_stall, 0);
        chk("rst.D_bubble", bus.D_bubble, 1);
        chk("rst.E_bubble", bus.E_bubble, 1);
        chk("rst.M_bubble", bus.M_bubble, 1);
        chk("rst.stall_cnt", bus.stall_cnt, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("fill.D_bubble", bus.D_bubble, 0);
        chk("fill.M_bubble", bus.M_bubble, 0);

        // Load-use: one stall cycle
        bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
        #1;
        chk("lu.F_stall", bus.F_stall, 1);
        chk("lu.D_stall", bus.D_stall, 1);
        chk("lu.E_bubble", bus.E_bubble, 1);
        chk("lu.D_bubble", bus.D_bubble, 0);
        chk("lu.cnt_before", bus.stall_cnt, 0);
        step();
        set_clean();
        chk("lu.cnt_after", bus.stall_cnt, 1);

        // RET walks D -> E -> M
        bus.D_icode = 4'h9;
        #1;
        chk("retD.F_stall", bus.F_stall, 1);
        chk("retD.D_bubble", bus.D_bubble, 1);
        step();
        bus.D_icode = 4'h1; bus.E_icode = 4'h9;
        #1;
        chk("retE.F_stall", bus.F_stall, 1);
        chk("retE.D_bubble", bus.D_bubble, 1);
        step();
        bus.E_icode = 4'h1; bus.M_icode = 4'h9;
        #1;
        chk("retM.F_stall", bus.F_stall, 1);
        chk("retM.D_bubble", bus.D_bubble, 1);
        step();
        set_clean();
        chk("ret.ret_cnt", bus.ret_cnt, 1);
        chk("ret.stall_cnt", bus.stall_cnt, 4);

        // Mispredict with RET in D
        bus.E_icode = 4'h7; bus.e_Cnd = 1'b0; bus.D_icode = 4'h9;
        #1;
        chk("mp.D_bubble", bus.D_bubble, 1);
        chk("mp.E_bubble", bus.E_bubble, 1);
        chk("mp.D_stall", bus.D_stall, 0);
        chk("mp.F_stall", bus.F_stall, 1);
        step();
        set_clean();
        chk("mp.flush_cnt", bus.flush_cnt, 1);

        // Exception drain: m_stat error, then W_stat error
        bus.m_stat = 2'd2;
        #1;
        chk("xm.M_bubble", bus.M_bubble, 1);
        step();
        bus.m_stat = 2'd0; bus.W_stat = 2'd2;
        #1;
        chk("drain.halted", bus.halted, 0);
        chk("drain.F_stall", bus.F_stall, 1);
        chk("drain.M_bubble", bus.M_bubble, 1);
        step();
        chk("halt.halted", bus.halted, 1);
        chk("halt.exit_stat", bus.exit_stat, 2);
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            #1;
            chk("hold.F_stall", bus.F_stall, 1);
            chk("hold.D_stall", bus.D_stall, 1);
            chk("hold.W_stall", bus.W_stall, 1);
            step();
        end
        chk("hold.exit_stat", bus.exit_stat, 2);
        chk("hold.stall_cnt", bus.stall_cnt, 5);
        chk("hold.flush_cnt", bus.flush_cnt, 1);
        chk("hold.ret_cnt", bus.ret_cnt, 2);

        // Reset mid-HALTED: immediate, asynchronous
        rst_n = 1'b0;
        set_clean();
        #1;
        chk("arst.halted", bus.halted, 0);
        chk("arst.stall_cnt", bus.stall_cnt, 0);
        chk("arst.D_bubble", bus.D_bubble, 1);
        chk("arst.E_bubble", bus.E_bubble, 1);
        chk("arst.M_bubble", bus.M_bubble, 1);
        #4;
        rst_n = 1'b1;
        step();
        chk("post.ctl", {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                         bus.M_bubble, bus.W_stall}, 0);
        chk("post.halted", bus.halted, 0);
        chk("post.exit_stat", bus.exit_stat, 0);

        // Saturation: hold a load-use hazard for 20 cycles
        bus.E_icode = 4'hB; bus.E_dstM = 4'h4; bus.d_srcB = 4'h4;
        repeat (20) step();
        chk("sat.stall_cnt4", bus4.stall_cnt, 15);
        chk("sat.stall_cnt16", bus.stall_cnt, 20);
        set_clean();

        // Randomized traffic in blocks, each from a fresh reset
        for (int blk = 0; blk < 6; blk++) begin
            pulse_reset();
            for (int i = 0; i < 80; i++) begin
                rand_inputs();
                step();
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Sequential pipeline controller for the five-stage Y86-64 pipeline. Each cycle it computes the stall and bubble controls for the F, D, E, M and W pipeline registers, including the D register's `D_stall`/`D_bubble` pair, from hazard information returned by the stages. It tracks halt/exception drain in a small state machine and keeps saturating performance counters. It sits beside the pipeline registers and is their only source of stall/bubble signals.

## Interface
- `CNT_W`, default 16: width of each performance counter.
- `clk`, in, 1: pipeline clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `D_icode`, in, 4: icode held in the D register.
- `d_srcA`, `d_srcB`, in, 4 each: decode-stage source register IDs; 4'hF means none.
- `E_icode`, in, 4: icode in the E register.
- `E_dstM`, in, 4: load destination in the E register.
- `e_Cnd`, in, 1: execute-stage condition result.
- `M_icode`, in, 4: icode in the M register.
- `m_stat`, in, 2: memory-stage status.
- `W_stat`, in, 2: W register status.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`, out, 1 each: pipeline register controls.
- `halted`, out, 1: pipeline frozen after an exception or halt retires.
- `exit_stat`, out, 2: status that froze the pipeline.
- `stall_cnt`, `flush_cnt`, `ret_cnt`, out, `CNT_W` each: saturating event counters.

## Operation
- Encodings:
  - icodes: HALT 0, NOP 1, JXX 7, RET 9, MRMOVQ 5, POPQ B.
  - stat: AOK 0, HLT 1, ADR 2, INS 3.
- Hazard terms, combinational:
  - `lu` = (E_icode ∈ {MRMOVQ, POPQ}) & E_dstM≠F & (E_dstM==d_srcA | E_dstM==d_srcB).
  - `rt` = RET ∈ {D_icode, E_icode, M_icode}.
  - `mp` = E_icode==JXX & !e_Cnd.
  - `xm` = m_stat≠AOK.
  - `xw` = W_stat≠AOK.
- FSM states: RUN, DRAIN, HALTED.
  - RUN→DRAIN when `xm` and not `xw`.
  - RUN→HALTED or DRAIN→HALTED when `xw`.
  - HALTED is left only by reset.
- Outputs in RUN:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (rt & !lu)
  - E_bubble = mp | lu
  - M_bubble = xm | xw
  - W_stall = xw
- Outputs in DRAIN: same as RUN, except M_bubble=1 and F_stall=1, so no new instruction commits memory or fetches.
- Outputs in HALTED: F_stall=1, D_stall=1, W_stall=1, M_bubble=1, D_bubble=0, E_bubble=0.
- Invariant: D_stall and D_bubble are never both 1. The same holds for F and W.
- `exit_stat` is loaded with W_stat on the RUN/DRAIN→HALTED edge and holds thereafter.
- `halted` = (state==HALTED), registered.
- Counters increment at most once per cycle, only in RUN, and saturate at all-ones:
  - `stall_cnt` increments when F_stall=1.
  - `flush_cnt` increments when mp=1.
  - `ret_cnt` increments when D_icode==RET and D_stall=0.

## Timing
- Control outputs are combinational from the current state and inputs. They act on the register capture at the next rising edge.
- Zero-cycle control latency; state, `halted` and `exit_stat` change one edge after the triggering input.
- While rst_n=0 and until the first edge after release:
  - state is RUN.
  - F_stall=0, D_stall=0, W_stall=0.
  - D_bubble=1, E_bubble=1, M_bubble=1 (pipeline fills with NOPs).
  - halted=0, exit_stat=0, all counters 0.
- Reset asserted mid-operation (any state) returns to these values immediately and asynchronously.
- A load-use hazard produces exactly one stall cycle for back-to-back dependent instructions.
- A RET in D produces three F-stall cycles (D, E, M occupancy); D is bubbled each of those cycles.
- A mispredict squashes exactly D and E in one cycle.
- `lu` and `rt` together: D_stall wins, D_bubble=0.
- `mp` with RET in D: D_bubble=1, F_stall=1.
- `xm` and `xw` in the same cycle: go directly to HALTED.

## Test plan
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 for one cycle.
  - Required: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, stall_cnt 0→1.
- RET walk: RET at D, then E, then M over three cycles.
  - Required: F_stall=1 and D_bubble=1 on each of the three cycles, ret_cnt=1, stall_cnt=3.
- Mispredict: E_icode=7, e_Cnd=0, D_icode=9.
  - Required: D_bubble=1, E_bubble=1, D_stall=0, flush_cnt=1.
- Exception drain: m_stat=2 for one cycle, then W_stat=2.
  - Required: DRAIN with M_bubble=1, then halted=1, exit_stat=2.
  - Required thereafter: F_stall=1, D_stall=1, W_stall=1 held for 10 cycles with counters frozen.
- Reset mid-HALTED: pulse rst_n=0 for half a cycle.
  - Required: halted=0 and counters 0 immediately, D_bubble=E_bubble=M_bubble=1.
  - Required: after release with clean inputs, all outputs 0.
- Saturation: with CNT_W=4, hold lu=1 for 20 cycles.
  - Required: stall_cnt stops at 15 with no wrap.
